fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the word-indexed instruction memory: owns the program counter and issues one read at a time over a req/valid handshake.
- Buffers returned words in a small FIFO for the decode stage, which consumes them over a valid/ready handshake.
- Handles branch/jump redirects, discarding any in-flight or buffered stale instructions.
- Stops fetching after the last programmed instruction and reports done.

Parameters:
- ADDR_W, 32, width of program counter / memory word index.
- NUM_INSTR, 3, number of instruction words loaded; valid indices 0..NUM_INSTR-1.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins fetching at index 0 (honoured in IDLE only).
- mem_req  output  1  read request; held high until mem_valid.
- mem_addr  output  ADDR_W  word index; stable while mem_req high.
- mem_valid  input  1  response strobe; may arrive in the same cycle as mem_req or later.
- mem_rdata  input  32  instruction word, valid with mem_valid.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode consumes head when instr_valid && instr_ready.
- instr  output  32  head instruction word.
- instr_pc  output  ADDR_W  index of head instruction.
- redirect_valid  input  1  branch/jump taken.
- redirect_pc  input  ADDR_W  new fetch index.
- done  output  1  high in DONE state.

Behaviour:
- Reset (async, reset_n low): state IDLE, pc=0, FIFO empty, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, done=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH on start, pc=0. redirect_valid is ignored in IDLE.
- FETCH: mem_req=1 when pc<NUM_INSTR and (fifo_count + outstanding) < FIFO_DEPTH; mem_addr=pc.
  - On mem_valid: push {mem_rdata, pc}, pc<=pc+1, drop mem_req next cycle unless another slot is free.
  - Back-to-back requests are allowed: new request in the cycle after mem_valid.
- FETCH -> DONE when pc==NUM_INSTR, nothing outstanding and FIFO empty.
- Redirect (FETCH/DRAIN/DONE), one cycle:
  - FIFO flushed; pc<=redirect_pc.
  - If a request is outstanding and mem_valid is not present this cycle: go to DRAIN.
  - Otherwise go to FETCH; a coincident mem_valid's data is discarded.
- DRAIN: keep mem_req=1 and mem_addr at the old index until mem_valid; discard that data, then go to FETCH. A further redirect in DRAIN only overwrites pc.
- redirect_pc>=NUM_INSTR: no fetch issued; go to DONE once nothing is outstanding.
- DONE: done=1, mem_req=0; redirect -> FETCH; start ignored.
- Latency:
  - start at cycle N -> mem_req=1, addr 0 at N+1.
  - mem_valid at cycle M -> instr_valid at M+1.
  - Redirect at cycle R -> instr_valid=0 at R+1; new request at R+1 (FETCH case).
- Simultaneous push and pop: both happen and count is unchanged. Pop and flush in the same cycle: flush wins.
- FIFO full with nothing outstanding: mem_req=0 until a pop. pc never exceeds NUM_INSTR except via redirect.
- pc arithmetic is ADDR_W-bit modular, with no other wrap handling.
- Reset mid-transfer: everything returns to the reset state immediately and any later mem_valid is ignored (IDLE).

Test Plan:
- Zero-wait memory (mem_valid=mem_req), instr_ready=1, start: addrs 0,1,2 on consecutive cycles; instr_pc 0,1,2 on instr_valid; done=1 after the third pop; mem_req never seen at addr 3.
- Backpressure: instr_ready=0, 3-cycle memory latency: 2 words buffered (pc 0,1), mem_req low with FIFO full; raising ready resumes at addr 2.
- Redirect to 0 while addr 2 is outstanding (latency 3): DRAIN holds addr 2 to mem_valid, data dropped; next request addr 0; instr_pc stream restarts at 0.
- Redirect coincident with mem_valid for addr 1: data dropped, FIFO empty, next request addr redirect_pc=2 at R+1.
- Redirect from DONE with redirect_pc=1: FETCH resumes, addrs 1,2 fetched, done again.
- reset_n low for 1 cycle mid-fetch: all outputs zero immediately, IDLE until next start, stale mem_valid ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, issues one instruction-memory
// read at a time and buffers returned words for decode in a small FIFO.
// Redirects flush the buffer and drain any read still in flight.
module fetch_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int NUM_INSTR  = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] END_PC  = ADDR_W'(NUM_INSTR);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       fifo_word [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];

  logic              flush;
  logic              accept;
  logic              hold;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              req_nxt;
  logic              go_done;

  // Per-cycle decisions: flush, push/pop, next pc/count and whether to request.
  // A request only goes out when the buffer has room for its response, so the
  // single outstanding read never overflows the FIFO.
  always_comb begin
    flush     = redirect_valid && (state != IDLE);
    accept    = mem_req && mem_valid;
    hold      = mem_req && !mem_valid;
    push      = accept && (state == FETCH) && !flush;
    pop       = instr_valid && instr_ready && !flush;
    count_nxt = flush ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    pc_nxt    = flush ? redirect_pc : (push ? pc + ADDR_W'(1) : pc);
    req_nxt   = (pc_nxt < END_PC) && (count_nxt < DEPTH_C);
    go_done   = !flush && !hold && (pc_nxt >= END_PC) && (count_nxt == '0);
  end

  // Sequencer FSM with registered request, address and done outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            pc       <= '0;
            mem_req  <= (END_PC != '0);
            mem_addr <= '0;
          end
        end
        FETCH: begin
          if (flush && hold) begin
            // Read still in flight: keep it asserted at the old index and drop its data.
            state <= DRAIN;
            pc    <= pc_nxt;
          end else begin
            pc <= pc_nxt;
            if (!hold) begin
              mem_req  <= req_nxt;
              mem_addr <= pc_nxt;
            end
            if (go_done) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          pc <= pc_nxt;
          if (mem_valid) begin
            state    <= FETCH;
            mem_req  <= req_nxt;
            mem_addr <= pc_nxt;
          end
        end
        DONE: begin
          if (flush) begin
            state    <= FETCH;
            done     <= 1'b0;
            pc       <= pc_nxt;
            mem_req  <= req_nxt;
            mem_addr <= pc_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer and beats a pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // FIFO storage: instruction word tagged with the index it was fetched from.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_word[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_word[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a latency-programmable memory responder.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;

  int checks   = 0;
  int errors   = 0;
  int bad_addr = 0;

  logic       mem_auto;
  logic       mem_force;
  logic [3:0] lat_m1;
  logic [3:0] wait_cnt;

  fetch_sequencer #(
    .ADDR_W(32),
    .NUM_INSTR(3),
    .FIFO_DEPTH(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .done(done)
  );

  always #5 clock = ~clock;

  // Memory responder: answers a request in its (lat_m1+1)-th cycle.
  assign mem_valid = mem_force | (mem_auto & mem_req & (wait_cnt == lat_m1));
  assign mem_rdata = {16'hC0DE, mem_addr[15:0]};

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 wait_cnt <= '0;
    else if (!mem_req || mem_valid) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 4'd1;
  end

  // Any request beyond the last programmed index is an error.
  always @(negedge clock) begin
    if (mem_req && (mem_addr >= 32'd3)) bad_addr <= bad_addr + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    mem_force = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mem_auto = 1'b1; mem_force = 1'b0; lat_m1 = 4'd0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_mem_req", mem_req, 0);

    // Zero-wait memory, decode always ready
    instr_ready = 1'b1; lat_m1 = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_req0", mem_req, 1);
    chk("t1_addr0", mem_addr, 0);
    chk("t1_iv0", instr_valid, 0);
    tick();
    chk("t1_iv_a", instr_valid, 1);
    chk("t1_pc_a", instr_pc, 0);
    chk("t1_instr_a", instr, 32'hC0DE_0000);
    chk("t1_addr1", mem_addr, 1);
    chk("t1_req1", mem_req, 1);
    tick();
    chk("t1_pc_b", instr_pc, 1);
    chk("t1_addr2", mem_addr, 2);
    tick();
    chk("t1_pc_c", instr_pc, 2);
    chk("t1_instr_c", instr, 32'hC0DE_0002);
    chk("t1_req_off", mem_req, 0);
    chk("t1_done_lo", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_iv_empty", instr_valid, 0);
    tick();
    chk("t1_done_hold", done, 1);
    chk("t1_req_done", mem_req, 0);

    // Backpressure with 3-cycle memory
    do_reset();
    instr_ready = 1'b0; lat_m1 = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_addr0", mem_addr, 0);
    tick(); tick(); tick();
    chk("t2_iv_a", instr_valid, 1);
    chk("t2_pc_a", instr_pc, 0);
    chk("t2_addr1", mem_addr, 1);
    tick(); tick(); tick();
    chk("t2_full_req", mem_req, 0);
    tick(); tick();
    chk("t2_full_req_hold", mem_req, 0);
    chk("t2_full_head", instr_pc, 0);
    instr_ready = 1'b1;
    tick();
    chk("t2_resume_req", mem_req, 1);
    chk("t2_resume_addr", mem_addr, 2);
    chk("t2_pc_b", instr_pc, 1);
    tick(); tick(); tick();
    chk("t2_pc_c", instr_pc, 2);
    chk("t2_req_end", mem_req, 0);
    tick();
    chk("t2_done", done, 1);

    // Redirect to 0 while addr 2 is outstanding
    do_reset();
    instr_ready = 1'b1; lat_m1 = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t3_pc_a", instr_pc, 0);
    tick(); tick(); tick();
    chk("t3_pc_b", instr_pc, 1);
    chk("t3_addr2", mem_addr, 2);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick(); redirect_valid = 1'b0;
    chk("t3_flush_iv", instr_valid, 0);
    chk("t3_drain_req", mem_req, 1);
    chk("t3_drain_addr", mem_addr, 2);
    tick();
    chk("t3_drain_addr_hold", mem_addr, 2);
    tick();
    chk("t3_refetch_req", mem_req, 1);
    chk("t3_refetch_addr", mem_addr, 0);
    chk("t3_dropped", instr_valid, 0);
    tick(); tick(); tick();
    chk("t3_restart_iv", instr_valid, 1);
    chk("t3_restart_pc", instr_pc, 0);
    chk("t3_restart_instr", instr, 32'hC0DE_0000);

    // Redirect coincident with mem_valid for addr 1
    do_reset();
    instr_ready = 1'b1; lat_m1 = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t4_pc_a", instr_pc, 0);
    chk("t4_addr1", mem_addr, 1);
    redirect_valid = 1'b1; redirect_pc = 32'd2;
    tick(); redirect_valid = 1'b0;
    chk("t4_flush_iv", instr_valid, 0);
    chk("t4_req", mem_req, 1);
    chk("t4_addr2", mem_addr, 2);
    tick();
    chk("t4_pc_c", instr_pc, 2);
    chk("t4_instr_c", instr, 32'hC0DE_0002);
    tick();
    chk("t4_done", done, 1);

    // From DONE: start ignored, redirect to 1 resumes fetching
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_ign_done", done, 1);
    chk("t5_start_ign_req", mem_req, 0);
    redirect_valid = 1'b1; redirect_pc = 32'd1;
    tick(); redirect_valid = 1'b0;
    chk("t5_done_lo", done, 0);
    chk("t5_req", mem_req, 1);
    chk("t5_addr1", mem_addr, 1);
    tick();
    chk("t5_pc_b", instr_pc, 1);
    chk("t5_addr2", mem_addr, 2);
    tick();
    chk("t5_pc_c", instr_pc, 2);
    chk("t5_req_end", mem_req, 0);
    tick();
    chk("t5_done", done, 1);

    // Reset mid-fetch
    do_reset();
    instr_ready = 1'b0; lat_m1 = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t6_pre_iv", instr_valid, 1);
    chk("t6_pre_req", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_req", mem_req, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_iv", instr_valid, 0);
    chk("t6_instr", instr, 0);
    chk("t6_instr_pc", instr_pc, 0);
    chk("t6_done", done, 0);
    tick();
    reset_n = 1'b1;
    mem_force = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd1;
    tick();
    mem_force = 1'b0; redirect_valid = 1'b0;
    chk("t6_stale_iv", instr_valid, 0);
    chk("t6_idle_req", mem_req, 0);
    tick();
    chk("t6_idle_req_hold", mem_req, 0);
    chk("t6_idle_done", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_restart_req", mem_req, 1);
    chk("t6_restart_addr", mem_addr, 0);

    tick();
    chk("no_addr_beyond_end", bad_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
